rf_wb_arbiter: RTL

- Shares the register file's single write port between two sources: the in-order pipeline writeback stage and a long-latency unit (multi-cycle mult/div result or cache-miss load return).
- Keeps a pending-write scoreboard so decode can stall on registers whose long-latency result has not yet landed.
- Sits between the writeback stage, the long-latency unit and the register file write port. It also drives a hazard signal to the decode stage.

---
 rtl/rf_wb_arbiter_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths, arbiter state encoding and decode helper
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending long-latency write vector with three lookup ports
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid) pending_d = pending_d & ~addr_onehot(clr_addr);
    if (set_valid) pending_d = pending_d | addr_onehot(set_addr);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hazard = pending_q[rs_addr] | pending_q[rt_addr] | pending_q[dst_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write port arbiter with starvation guard and hazard scoreboard
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  lu_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  output logic                  hazard,
  output logic                  wb_hold,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic                  proto_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             wb_hold_q;
  logic             proto_err_q;
  logic             force_slot;
  logic             lu_accept;
  logic             lu_blocked;

  assign force_slot = (state_q == ST_FORCE);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    lu_ready = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = pipe_addr;
    rf_data  = pipe_data;
    if (pipe_we && !force_slot) begin
      rf_we = 1'b1;
    end else begin
      lu_ready = lu_valid | force_slot;
      rf_we    = lu_valid;
      rf_addr  = lu_addr;
      rf_data  = lu_data;
    end
  end

  assign lu_accept  = lu_valid & lu_ready;
  assign lu_blocked = lu_valid & pipe_we & !force_slot;

  // cnt_q is zero in IDLE, so IDLE and WAIT share the blocked-cycle count path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wb_hold_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (pipe_we && wb_hold_q) proto_err_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (lu_blocked) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= LIMIT) begin
              state_q   <= ST_FORCE;
              wb_hold_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_FORCE: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          wb_hold_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          wb_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_hold   = wb_hold_q;
  assign proto_err = proto_err_q;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (iss_valid && (iss_addr != '0)),
    .set_addr  (iss_addr),
    .clr_valid (lu_accept),
    .clr_addr  (lu_addr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .dst_addr  (dst_addr),
    .hazard    (hazard)
  );

endmodule
